// File: rtl/fanout_capture_sched_if.sv
// fanout_capture_sched_if: request/grant, source data and capture-bank signals for the scheduler
interface fanout_capture_sched_if #(parameter int NREQ = 11, parameter int DELAY = 5, parameter int DW = 1);
  localparam int CW = $clog2(DELAY + 1);
  logic stall;
  logic [NREQ-1:0] req;
  logic [DW-1:0] din;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic [NREQ-1:0] busy;
  logic [NREQ*DW-1:0] cap_q;
  logic [CW-1:0] inflight;
  modport master(output stall, req, din, input gnt, done, busy, cap_q, inflight);
  modport slave(input stall, req, din, output gnt, done, busy, cap_q, inflight);
endinterface

// File: rtl/fanout_capture_sched.sv
// fanout_capture_sched: round-robin sequencer feeding one launch register and delay pipe into a capture bank
module fanout_capture_sched #(parameter int NREQ = 11, parameter int DELAY = 5, parameter int DW = 1) (
  input logic clk,
  input logic rst,
  fanout_capture_sched_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(DELAY + 1);
  localparam logic [IW:0] NR = (IW+1)'(NREQ);
  logic [DELAY-1:0] vld;
  logic [IW-1:0] pid [DELAY];
  logic [DW-1:0] pdat [DELAY];
  logic [IW-1:0] ptr, off, win;
  logic [IW:0] sum;
  logic [NREQ-1:0] elig, busy_n;
  logic [2*NREQ-1:0] dbl;
  logic grant, cap;
  logic [CW-1:0] cnt_n;
  // rotate eligibility so the pointer sits at bit 0, then take the lowest set bit
  always_comb begin
    elig = bus.req & ~bus.busy;
    dbl = {elig, elig} >> ptr;
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--) if (dbl[k]) off = IW'(k);
    sum = {1'b0, ptr} + {1'b0, off};
    win = IW'(sum >= NR ? sum - NR : sum);
    grant = ~bus.stall & |elig;
    cap = ~bus.stall & vld[DELAY-1];
    busy_n = (bus.busy & ~(cap ? NREQ'(1) << pid[DELAY-1] : '0)) | (grant ? NREQ'(1) << win : '0);
    cnt_n = CW'(grant);
    for (int k = 0; k < DELAY - 1; k++) cnt_n = cnt_n + CW'(vld[k]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      ptr <= '0;
      bus.gnt <= '0;
      bus.done <= '0;
      bus.busy <= '0;
      bus.cap_q <= '0;
      bus.inflight <= '0;
    end else begin
      bus.gnt <= grant ? NREQ'(1) << win : '0;
      bus.done <= cap ? NREQ'(1) << pid[DELAY-1] : '0;
      if (!bus.stall) begin
        vld[0] <= grant;
        pid[0] <= win;
        pdat[0] <= bus.din;
        for (int k = 1; k < DELAY; k++) begin
          vld[k] <= vld[k-1];
          pid[k] <= pid[k-1];
          pdat[k] <= pdat[k-1];
        end
        bus.busy <= busy_n;
        bus.inflight <= cnt_n;
        if (grant) ptr <= win == IW'(NREQ - 1) ? '0 : win + 1'b1;
        if (cap) bus.cap_q[pid[DELAY-1]*DW +: DW] <= pdat[DELAY-1];
      end
    end
  end
endmodule

// File: tb/tb_fanout_capture_sched.sv
// tb_fanout_capture_sched: directed vectors with hand-computed grant, done and capture expectations
module tb_fanout_capture_sched;
  localparam int NREQ = 11, DELAY = 5, DW = 8;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  fanout_capture_sched_if #(.NREQ(NREQ), .DELAY(DELAY), .DW(DW)) bus();
  fanout_capture_sched #(.NREQ(NREQ), .DELAY(DELAY), .DW(DW)) dut(.clk(clk), .rst(rst), .bus(bus));
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1;
    bus.req = '0;
    bus.stall = 0;
    bus.din = '0;
    tick();
    rst = 0;
  endtask
  function automatic logic [NREQ-1:0] oh(input int i);
    return NREQ'(1) << i;
  endfunction
  function automatic logic [127:0] w(input logic [NREQ-1:0] v);
    return 128'(v);
  endfunction
  initial begin
    do_reset();
    chk("rst_gnt", w(bus.gnt), 0);
    chk("rst_done", w(bus.done), 0);
    chk("rst_busy", w(bus.busy), 0);
    chk("rst_cap", 128'(bus.cap_q), 0);
    chk("rst_infl", 128'(bus.inflight), 0);
    // single request
    bus.req = oh(3);
    bus.din = 8'hA5;
    tick();
    chk("single_gnt", w(bus.gnt), w(oh(3)));
    chk("single_busy", w(bus.busy), w(oh(3)));
    chk("single_infl", 128'(bus.inflight), 1);
    bus.req = '0;
    bus.din = 8'h00;
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk("single_nodone", w(bus.done), 0);
      chk("single_infl_mid", 128'(bus.inflight), 1);
    end
    tick();
    chk("single_done", w(bus.done), w(oh(3)));
    chk("single_cap", 128'(bus.cap_q), 128'(88'hA5) << 24);
    chk("single_busy_clr", w(bus.busy), 0);
    chk("single_infl_end", 128'(bus.inflight), 0);
    // round robin with all requesters held
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      bus.req = c <= 11 ? '1 : '0;
      bus.din = 8'(c);
      tick();
      chk("rr_gnt", w(bus.gnt), c <= 11 ? w(oh(c % 11)) : 0);
      chk("rr_done", w(bus.done), (c >= 5 && c <= 16) ? w(oh((c - 5) % 11)) : 0);
      if (c >= 4 && c <= 11) chk("rr_infl", 128'(bus.inflight), 5);
    end
    chk("rr_infl_end", 128'(bus.inflight), 0);
    chk("rr_slice0", 128'(bus.cap_q[0 +: DW]), 11);
    for (int i = 1; i < NREQ; i++) chk("rr_slice", 128'(bus.cap_q[i*DW +: DW]), 128'(i));
    // same requester re-requests continuously
    do_reset();
    bus.req = oh(2);
    for (int c = 0; c <= 12; c++) begin
      tick();
      chk("rereq_gnt", w(bus.gnt), c % 6 == 0 ? w(oh(2)) : 0);
      chk("rereq_done", w(bus.done), (c == 5 || c == 11) ? w(oh(2)) : 0);
      chk("rereq_busy", w(bus.busy), c % 6 == 5 ? 0 : w(oh(2)));
    end
    // stall mid-flight
    do_reset();
    bus.req = oh(7);
    bus.din = 8'h3C;
    tick();
    chk("stall_gnt", w(bus.gnt), w(oh(7)));
    bus.req = '0;
    bus.din = 8'hFF;
    tick();
    bus.stall = 1;
    bus.req = oh(1);
    for (int e = 2; e <= 4; e++) begin
      tick();
      chk("stall_gnt0", w(bus.gnt), 0);
      chk("stall_done0", w(bus.done), 0);
      chk("stall_infl", 128'(bus.inflight), 1);
      chk("stall_busy", w(bus.busy), w(oh(7)));
    end
    bus.stall = 0;
    bus.req = '0;
    for (int e = 5; e <= 7; e++) begin
      tick();
      chk("stall_wait", w(bus.done), 0);
    end
    tick();
    chk("stall_done", w(bus.done), w(oh(7)));
    chk("stall_cap", 128'(bus.cap_q), 128'(88'h3C) << 56);
    chk("stall_busy_end", w(bus.busy), 0);
    chk("drop_gnt", w(bus.gnt), 0);
    // reset with three samples in flight
    do_reset();
    bus.req = oh(1) | oh(4) | oh(9);
    bus.din = 8'h11;
    tick();
    chk("mid_g1", w(bus.gnt), w(oh(1)));
    bus.req = oh(4) | oh(9);
    tick();
    chk("mid_g4", w(bus.gnt), w(oh(4)));
    bus.req = oh(9);
    tick();
    chk("mid_g9", w(bus.gnt), w(oh(9)));
    bus.req = '0;
    tick();
    chk("mid_infl", 128'(bus.inflight), 3);
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_gnt", w(bus.gnt), 0);
    chk("mid_rst_busy", w(bus.busy), 0);
    chk("mid_rst_infl", 128'(bus.inflight), 0);
    chk("mid_rst_cap", 128'(bus.cap_q), 0);
    for (int e = 0; e < 6; e++) begin
      tick();
      chk("mid_nodone", w(bus.done), 0);
    end
    bus.req = oh(4) | oh(10);
    tick();
    chk("mid_ptr0", w(bus.gnt), w(oh(4)));
    bus.req = '0;
    // pointer wrap
    do_reset();
    bus.req = oh(10);
    tick();
    chk("wrap_g10", w(bus.gnt), w(oh(10)));
    bus.req = '0;
    for (int e = 1; e <= 5; e++) tick();
    chk("wrap_done10", w(bus.done), w(oh(10)));
    bus.req = oh(0) | oh(10);
    tick();
    chk("wrap_g0", w(bus.gnt), w(oh(0)));
    chk("wrap_busy", w(bus.busy), w(oh(0)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
